// File: rtl/scope_trace_pkg.sv
// Package PKGScope: shared types and default geometry for the scope trace
// capture block.
//   state_e        : capture state encoding (ARMED=0, CAPTURE=1, DONE=2)
//   *_DEF          : default channel count, sample width, trace depth,
//                    plot height and decimation width
//   Y_BITS_DEF     : bits needed for one scaled trace height
//   ADDR_BITS_DEF  : bits needed to address one trace column
package PKGScope;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int unsigned CHANNELS_DEF    = 2;
  localparam int unsigned SAMPLE_BITS_DEF = 12;
  localparam int unsigned DEPTH_DEF       = 518;
  localparam int unsigned PLOT_H_DEF      = 159;
  localparam int unsigned DECIM_BITS_DEF  = 8;
  localparam int unsigned Y_BITS_DEF      = $clog2(PLOT_H_DEF);
  localparam int unsigned ADDR_BITS_DEF   = $clog2(DEPTH_DEF);

endpackage

// File: rtl/scope_trace_if.sv
// Interface scope_trace_if: ADC sample stream into the trace capture block.
//   sample       : CHANNELS x SAMPLE_BITS conversion results
//   sample_valid : single-cycle strobe per conversion
// Modports: master drives the stream (ADC side), slave receives it.
interface scope_trace_if #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SAMPLE_BITS = 12
);

  logic [CHANNELS-1:0][SAMPLE_BITS-1:0] sample;
  logic                                 sample_valid;

  modport master (output sample, output sample_valid);
  modport slave  (input  sample, input  sample_valid);

endinterface

// File: rtl/scope_trace_ram.sv
// scope_trace_ram: one half of the ping-pong trace store.
//   clk      : system clock
//   we_i     : write enable
//   waddr_i  : write column
//   wdata_i  : packed scaled heights, channel c at bits [c*Y_BITS +: Y_BITS]
//   raddr_i  : read column
//   rdata_o  : registered read data, one cycle after raddr_i
// Contents are never cleared; out-of-range reads leave rdata_o unchanged and
// are masked by the parent.
module scope_trace_ram
  import PKGScope::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned WIDTH = CHANNELS_DEF * Y_BITS_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if ({1'b0, raddr_i} < (AW + 1)'(DEPTH)) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/scope_trace.sv
// scope_trace: decimating, optionally triggered oscilloscope trace capture
// into a ping-pong buffer pair that swaps only at vertical blank.
//   clk, rst_n   : system clock, synchronous active-low reset
//   smp          : ADC sample stream (scope_trace_if.slave)
//   decim        : keep 1 of every decim+1 strobes
//   trig_mode    : 0 free-run, 1 rising-edge trigger on channel 0
//   trig_level   : trigger threshold
//   hold         : blocks the start of a new capture
//   frame_sync   : vertical-blank pulse, buffer swap point once DONE
//   rd_addr      : display column
//   rd_data      : scaled heights from the front buffer, 1-cycle latency,
//                  zero for rd_addr >= DEPTH
//   state        : ARMED=0, CAPTURE=1, DONE=2
// Build option: define SCOPE_TRIGGER_EN to implement the trigger; without it
// trig_mode/trig_level are ignored and ARMED always behaves as free-run.
module scope_trace
  import PKGScope::*;
#(
  parameter  int unsigned CHANNELS    = CHANNELS_DEF,
  parameter  int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter  int unsigned DEPTH       = DEPTH_DEF,
  parameter  int unsigned PLOT_H      = PLOT_H_DEF,
  parameter  int unsigned DECIM_BITS  = DECIM_BITS_DEF,
  localparam int unsigned Y_BITS      = $clog2(PLOT_H),
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  scope_trace_if.slave                     smp,
  input  logic [DECIM_BITS-1:0]            decim,
  input  logic                             trig_mode,
  input  logic [SAMPLE_BITS-1:0]           trig_level,
  input  logic                             hold,
  input  logic                             frame_sync,
  input  logic [AW-1:0]                    rd_addr,
  output logic [CHANNELS-1:0][Y_BITS-1:0]  rd_data,
  output logic [1:0]                       state
);

  localparam int unsigned PW   = SAMPLE_BITS + $clog2(PLOT_H) + 1;
  localparam int unsigned FULL = (2 ** SAMPLE_BITS) - 1;
  localparam int unsigned W    = CHANNELS * Y_BITS;

  state_e                  state_q, state_d;
  logic [AW-1:0]           wr_idx_q, wr_idx_d;
  logic [DECIM_BITS-1:0]   dec_q, dec_d;
  logic                    front_q, front_d;
  logic                    rd_ok_q, rd_sel_q;
  logic                    accept, start_ok, wr_en;
  logic [AW-1:0]           wr_addr;
  logic [W-1:0]            wr_data;
  logic [W-1:0]            rdata0, rdata1;
  logic [CHANNELS-1:0][PW-1:0] prod, quot;

  // Decimator runs in every state so the kept phase never drifts.
  always_comb begin
    dec_d = dec_q;
    if (smp.sample_valid) begin
      dec_d = (dec_q >= decim) ? '0 : dec_q + 1'b1;
    end
  end

  assign accept = smp.sample_valid && (dec_q == '0);

  // Full-width product before the divide keeps the scaling exact.
  always_comb begin
    wr_data = '0;
    prod    = '0;
    quot    = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      prod[c] = PW'(smp.sample[c]) * PW'(PLOT_H);
      quot[c] = prod[c] / PW'(FULL);
      if (quot[c] >= PW'(PLOT_H - 1)) begin
        wr_data[c*Y_BITS +: Y_BITS] = Y_BITS'(PLOT_H - 1);
      end else begin
        wr_data[c*Y_BITS +: Y_BITS] = quot[c][Y_BITS-1:0];
      end
    end
  end

`ifdef SCOPE_TRIGGER_EN
  logic [SAMPLE_BITS-1:0] prev_q;

  // History tracks every accepted sample, including while held or DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else if (accept) begin
      prev_q <= smp.sample[0];
    end
  end

  assign start_ok = !trig_mode ||
                    ((prev_q < trig_level) && (smp.sample[0] >= trig_level));
`else
  logic unused_trig;
  assign unused_trig = ^{trig_mode, trig_level};
  assign start_ok    = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    front_d  = front_q;
    wr_en    = 1'b0;
    wr_addr  = wr_idx_q;
    case (state_q)
      ST_ARMED: begin
        if (accept && !hold && start_ok) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_idx_d = AW'(1);
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (wr_idx_q == AW'(DEPTH - 1)) begin
            wr_idx_d = '0;
            state_d  = ST_DONE;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (frame_sync) begin
          front_d = ~front_q;
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ARMED;
      wr_idx_q <= '0;
      dec_q    <= '0;
      front_q  <= 1'b0;
      rd_ok_q  <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      dec_q    <= dec_d;
      front_q  <= front_d;
      rd_ok_q  <= ({1'b0, rd_addr} < (AW + 1)'(DEPTH));
      rd_sel_q <= front_q;
    end
  end

  // front_q selects the buffer being displayed; the other one is written.
  scope_trace_ram #(.DEPTH(DEPTH), .WIDTH(W)) u_ram0 (
    .clk     (clk),
    .we_i    (wr_en && front_q),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  scope_trace_ram #(.DEPTH(DEPTH), .WIDTH(W)) u_ram1 (
    .clk     (clk),
    .we_i    (wr_en && !front_q),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  assign rd_data = rd_ok_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
  assign state   = state_q;

endmodule

// File: tb/tb_scope_trace.sv
// tb_scope_trace: scoreboard bench for scope_trace. Expected column contents
// are queued as samples are driven and compared on readback after the swap.
module tb_scope_trace;
  import PKGScope::*;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic [7:0]                   decim = '0;
  logic                         trig_mode = 1'b0;
  logic [11:0]                  trig_level = '0;
  logic                         hold = 1'b0;
  logic                         frame_sync = 1'b0;
  logic [ADDR_BITS_DEF-1:0]     rd_addr = '0;
  logic [1:0][Y_BITS_DEF-1:0]   rd_data;
  logic [1:0]                   state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         addr;
    logic [7:0] y0;
    logic [7:0] y1;
  } exp_t;
  exp_t sb[$];

  scope_trace_if #(.CHANNELS(2), .SAMPLE_BITS(12)) smp_if ();

  scope_trace dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smp        (smp_if),
    .decim      (decim),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .hold       (hold),
    .frame_sync (frame_sync),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] scale(input int s);
    int q;
    q = (s * 159) / 4095;
    if (q > 158) q = 158;
    return 8'(q);
  endfunction

  function automatic int ramp(input int k);
    return (k * 4095) / 517;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int s0, input int s1, input bit fs);
    smp_if.sample[0]    = 12'(s0);
    smp_if.sample[1]    = 12'(s1);
    smp_if.sample_valid = 1'b1;
    frame_sync          = fs;
    tick();
    smp_if.sample_valid = 1'b0;
    frame_sync          = 1'b0;
  endtask

  task automatic push(input int a, input int s0, input int s1);
    exp_t e;
    e.addr = a;
    e.y0   = scale(s0);
    e.y1   = scale(s1);
    sb.push_back(e);
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      rd_addr = ADDR_BITS_DEF'(e.addr);
      tick();
      chk($sformatf("%s[%0d]", tag, e.addr), 32'(rd_data), {16'h0, e.y1, e.y0});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'(ST_ARMED));
    chk("rst_rd", 32'(rd_data), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    smp_if.sample       = '0;
    smp_if.sample_valid = 1'b0;

    // Free-run ramp capture, then swap and read every column.
    do_reset();
    pulse_fs();
    chk("fs_armed", 32'(state), 32'(ST_ARMED));
    for (int k = 0; k < 518; k++) begin
      strobe(ramp(k), 4095 - ramp(k), 1'b0);
      push(k, ramp(k), 4095 - ramp(k));
      if (k == 0) chk("cap_start", 32'(state), 32'(ST_CAPTURE));
    end
    chk("done1", 32'(state), 32'(ST_DONE));
    strobe(1234, 1234, 1'b0);
    chk("done_ignore", 32'(state), 32'(ST_DONE));
    pulse_fs();
    chk("swap1", 32'(state), 32'(ST_ARMED));
    drain("ramp");
    rd_addr = ADDR_BITS_DEF'(600);
    tick();
    chk("rd_oor", 32'(rd_data), 32'h0);

    // frame_sync mid-capture and on the final write must not swap.
    for (int k = 0; k < 518; k++) begin
      strobe((k * 7) % 4096, 2000, (k == 100) || (k == 517));
      push(k, (k * 7) % 4096, 2000);
    end
    chk("done2", 32'(state), 32'(ST_DONE));
    for (int k = 0; k < 518; k += 100) begin
      rd_addr = ADDR_BITS_DEF'(k);
      tick();
      chk($sformatf("front_hold[%0d]", k), 32'(rd_data),
          {16'h0, scale(4095 - ramp(k)), scale(ramp(k))});
    end
    pulse_fs();
    chk("swap2", 32'(state), 32'(ST_ARMED));
    pulse_fs();
    chk("fs_armed2", 32'(state), 32'(ST_ARMED));
    drain("swp");

    // hold keeps the block in ARMED.
    do_reset();
    hold = 1'b1;
    repeat (5) strobe(3000, 3000, 1'b0);
    chk("hold", 32'(state), 32'(ST_ARMED));
    hold = 1'b0;
    strobe(3000, 3000, 1'b0);
    chk("hold_rel", 32'(state), 32'(ST_CAPTURE));

    // decim=3: 2072 strobes produce exactly 518 writes.
    do_reset();
    decim = 8'd3;
    for (int n = 0; n < 2072; n++) begin
      if (n == 2068) chk("pre_last", 32'(state), 32'(ST_CAPTURE));
      strobe(n, 4095 - n, 1'b0);
      if (n % 4 == 0) push(n / 4, n, 4095 - n);
      if (n == 2068) chk("last", 32'(state), 32'(ST_DONE));
    end
    chk("done3", 32'(state), 32'(ST_DONE));
    pulse_fs();
    chk("swap3", 32'(state), 32'(ST_ARMED));
    drain("dec");
    decim = 8'd0;

    // Reset mid-capture abandons the trace; next capture starts at 0.
    do_reset();
    for (int k = 0; k < 200; k++) strobe(k * 20, 50, 1'b0);
    chk("cap200", 32'(state), 32'(ST_CAPTURE));
    rst_n   = 1'b0;
    rd_addr = ADDR_BITS_DEF'(5);
    tick();
    chk("midrst_state", 32'(state), 32'(ST_ARMED));
    chk("midrst_rd", 32'(rd_data), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 518; k++) begin
      strobe(4000 - k * 5, k * 3, 1'b0);
      push(k, 4000 - k * 5, k * 3);
    end
    chk("done4", 32'(state), 32'(ST_DONE));
    pulse_fs();
    drain("rst");

`ifdef SCOPE_TRIGGER_EN
    // Rising-edge trigger at 2048 on a 1000->3000 sweep.
    do_reset();
    trig_mode  = 1'b1;
    trig_level = 12'd2048;
    idx = 0;
    for (int v = 1000; v <= 3000; v += 10) begin
      strobe(v, 100, 1'b0);
      if (v == 2040) chk("trig_wait", 32'(state), 32'(ST_ARMED));
      if (v >= 2050) begin
        push(idx, v, 100);
        idx++;
      end
    end
    while (idx < 518) begin
      strobe(3000, 100, 1'b0);
      push(idx, 3000, 100);
      idx++;
    end
    chk("done_trig", 32'(state), 32'(ST_DONE));
    pulse_fs();
    drain("trig");
    repeat (20) strobe(3000, 100, 1'b0);
    chk("above", 32'(state), 32'(ST_ARMED));
    strobe(1000, 100, 1'b0);
    strobe(2100, 100, 1'b0);
    chk("retrig", 32'(state), 32'(ST_CAPTURE));
`else
    // Without the trigger option ARMED is always free-run.
    do_reset();
    trig_mode  = 1'b1;
    trig_level = 12'd2048;
    idx = 0;
    strobe(100, 100, 1'b0);
    chk("trig_ignored", 32'(state), 32'(ST_CAPTURE));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scope_trace.md
SCOPE_TRACE -- requirements
Module: scope_trace

Interface
REQ-001 Parameter CHANNELS, default 2, number of ADC traces captured.
REQ-002 Parameter SAMPLE_BITS, default 12, ADC sample width.
REQ-003 Parameter DEPTH, default 518, trace length in samples (plot width in pixels).
REQ-004 Parameter PLOT_H, default 159, plot height in pixels; Y_BITS = clog2(PLOT_H).
REQ-005 Parameter DECIM_BITS, default 8, decimation control width.
REQ-006 Clock and reset: one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  system clock.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 sample  in  CHANNELS x SAMPLE_BITS  ADC samples, valid with sample_valid.
REQ-010 sample_valid  in  1  single-cycle strobe per ADC conversion.
REQ-011 decim  in  DECIM_BITS  keep 1 of every decim+1 strobes.
REQ-012 trig_mode  in  1  0 = free-run, 1 = rising-edge trigger on channel 0.
REQ-013 trig_level  in  SAMPLE_BITS  trigger threshold.
REQ-014 hold  in  1  high blocks start of a new capture.
REQ-015 frame_sync  in  1  single-cycle pulse at vertical blank; buffer swap point.
REQ-016 rd_addr  in  clog2(DEPTH)  display column index.
REQ-017 rd_data  out  CHANNELS x Y_BITS  scaled trace heights from front buffer.
REQ-018 state  out  2  ARMED=0, CAPTURE=1, DONE=2.

Function
REQ-019 Decimator counter increments on each sample_valid, wraps to 0 after reaching decim; a strobe is accepted when counter is 0; counter runs in all states.
REQ-020 Scaling: y = min((sample * PLOT_H) / (2^SAMPLE_BITS - 1), PLOT_H - 1), product computed at SAMPLE_BITS + clog2(PLOT_H)+1 bits, no truncation before divide.
REQ-021 ARMED: free-run -> CAPTURE on next accepted sample, which is written at index 0; triggered -> CAPTURE on accepted sample where previous accepted ch0 < trig_level and current ch0 >= trig_level; that sample written at index 0.
REQ-022 ARMED with hold high does not leave ARMED; trigger history still updates.
REQ-023 CAPTURE: each accepted sample writes all channels' scaled values to back buffer at wr_idx, wr_idx increments; write at DEPTH-1 -> DONE, wr_idx to 0.
REQ-024 DONE: ignores accepted samples; on frame_sync swaps front/back and returns to ARMED next cycle.
REQ-025 frame_sync in ARMED or CAPTURE: no effect; front buffer never changes mid-frame.
REQ-026 frame_sync coincident with final CAPTURE write: write completes, state DONE, swap waits for next frame_sync.
REQ-027 rd_data registered, latency 1 cycle from rd_addr; rd_addr >= DEPTH returns all-zero.
REQ-028 Reads and writes target different buffers; simultaneous access never conflicts.

Reset
REQ-029 On rst_n low at clk edge: state=ARMED, wr_idx=0, decimator=0, front select=0, trigger history=0, rd_data=0.
REQ-030 Reset mid-CAPTURE abandons partial trace; buffer RAM contents are not cleared.

Configuration
REQ-031 Macro SCOPE_TRIGGER_EN defined: trig_mode, trig_level and trigger history implemented per REQ-021.
REQ-032 SCOPE_TRIGGER_EN undefined: trigger logic absent, trig_mode/trig_level ignored, ARMED always behaves as free-run.

Structure
REQ-033 Package PKGScope holds state enum, default CHANNELS/DEPTH/PLOT_H, Y_BITS and address-width constants.
REQ-034 Sub-module scope_trace_ram: one write port, one registered read port, DEPTH x (CHANNELS*Y_BITS); two instances form the ping-pong pair.

Verification
REQ-035 Free-run, decim=0, ramp 0..517 on ch0 full-scale steps, frame_sync -> rd_addr=k returns scaled ramp, state ARMED after swap.
REQ-036 decim=3, 2072 strobes -> exactly 518 writes, DONE after 2072nd strobe.
REQ-037 Triggered, level=2048, ch0 sweeps 1000->3000 -> first stored sample is first value >= 2048; staying above level never triggers.
REQ-038 sample=4095 -> y=158; sample=0 -> y=0; rd_addr=600 -> rd_data 0.
REQ-039 frame_sync during CAPTURE and on final write cycle -> front unchanged; swap on next frame_sync.
REQ-040 rst_n low mid-CAPTURE at wr_idx 200 -> state ARMED, next capture writes from index 0, rd_data 0 one cycle after reset.
